// File: rtl/gmii_frame_check.sv
// GMII receive-side frame checker: CRC-32 and length checks, framed output stream, per-class counters.
// Optional FCS stripping is enabled by defining GMII_FCS_STRIP_EN (5-byte hold line instead of 1).
module gmii_frame_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        pkt_err,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_bad_fcs,
    output logic [31:0] cnt_bad_len
);

`ifdef GMII_FCS_STRIP_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1;
`endif

    localparam logic [15:0] HOLD_L    = 16'(HOLD);
    localparam logic [15:0] MIN_L     = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L     = 16'(MAX_LEN);
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_RESID = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        SKIP  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2
    } state_t;

    // Exposed for checkers bound into the design.
    state_t state;

    logic [8*HOLD-1:0] hold;
    logic [8*HOLD+7:0] shifted;
    logic [7:0]        oldest;
    logic [31:0]       crc;
    logic [15:0]       len;
    logic              rx_er_seen;
    logic              len_bad;
    logic              crc_bad;
    logic              frame_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Hold line: newest byte enters at the bottom, the byte due for output sits at the top.
    assign shifted   = {hold, gmii_rxd};
    assign oldest    = hold[8*HOLD-1 -: 8];
    assign len_bad   = (len < MIN_L) || (len > MAX_L);
    assign crc_bad   = (crc != CRC_RESID);
    assign frame_bad = len_bad || crc_bad || rx_er_seen;

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SKIP;
            hold        <= '0;
            crc         <= '1;
            len         <= '0;
            rx_er_seen  <= 1'b0;
            pkt_data    <= '0;
            pkt_valid   <= 1'b0;
            pkt_sop     <= 1'b0;
            pkt_eop     <= 1'b0;
            pkt_err     <= 1'b0;
            cnt_good    <= '0;
            cnt_bad_fcs <= '0;
            cnt_bad_len <= '0;
        end else begin
            pkt_valid <= 1'b0;
            pkt_sop   <= 1'b0;
            pkt_eop   <= 1'b0;
            pkt_err   <= 1'b0;
            case (state)
                SKIP: begin
                    if (!gmii_rx_dv) state <= IDLE;
                end
                IDLE: begin
                    if (gmii_rx_dv) begin
                        hold       <= shifted[8*HOLD-1:0];
                        crc        <= crc_byte(32'hFFFF_FFFF, gmii_rxd);
                        len        <= 16'd1;
                        rx_er_seen <= gmii_rx_er;
                        state      <= FRAME;
                    end
                end
                FRAME: begin
                    if (gmii_rx_dv) begin
                        hold       <= shifted[8*HOLD-1:0];
                        crc        <= crc_byte(crc, gmii_rxd);
                        len        <= (len == 16'hFFFF) ? len : len + 16'd1;
                        rx_er_seen <= rx_er_seen | gmii_rx_er;
                        if (len >= HOLD_L) begin
                            pkt_valid <= 1'b1;
                            pkt_data  <= oldest;
                            pkt_sop   <= (len == HOLD_L);
                        end
                    end else begin
                        // End event: flush the last kept byte and classify the frame.
                        state <= IDLE;
                        if (len >= HOLD_L) begin
                            pkt_valid <= 1'b1;
                            pkt_data  <= oldest;
                            pkt_sop   <= (len == HOLD_L);
                            pkt_eop   <= 1'b1;
                            pkt_err   <= frame_bad;
                        end
                        if (len_bad)
                            cnt_bad_len <= cnt_bad_len + 32'd1;
                        else if (crc_bad || rx_er_seen)
                            cnt_bad_fcs <= cnt_bad_fcs + 32'd1;
                        else
                            cnt_good <= cnt_good + 32'd1;
                    end
                end
                default: state <= SKIP;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_frame_check.sv
// Testbench for gmii_frame_check: random frames against a byte-queue reference model.
// Follows the GMII_FCS_STRIP_EN setting of the build.
module tb_gmii_frame_check;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
`ifdef GMII_FCS_STRIP_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1;
`endif

    logic        clk_125m = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  pkt_data;
    logic        pkt_valid, pkt_sop, pkt_eop, pkt_err;
    logic [31:0] cnt_good, cnt_bad_fcs, cnt_bad_len;

    gmii_frame_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk_125m(clk_125m), .rst_n(rst_n),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop),
        .pkt_eop(pkt_eop), .pkt_err(pkt_err),
        .cnt_good(cnt_good), .cnt_bad_fcs(cnt_bad_fcs), .cnt_bad_len(cnt_bad_len)
    );

    // ---------------- clock / reset ----------------
    always #4 clk_125m = ~clk_125m;

    int cyc = 0;
    always @(posedge clk_125m) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor ----------------
    logic [10:0] obs_q[$];
    logic [95:0] obs_cnt_q[$];
    int          obs_eop_cyc[$];
    int          stray = 0;

    always @(negedge clk_125m) begin
        if (rst_n) begin
            if (pkt_valid) begin
                obs_q.push_back({pkt_err, pkt_eop, pkt_sop, pkt_data});
                if (pkt_eop) begin
                    obs_eop_cyc.push_back(cyc);
                    obs_cnt_q.push_back({cnt_good, cnt_bad_fcs, cnt_bad_len});
                end
            end
            if (pkt_err && !(pkt_valid && pkt_eop)) stray++;
            if (!pkt_valid && (pkt_sop || pkt_eop)) stray++;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [10:0] exp_q[$];
    logic [95:0] exp_cnt_q[$];
    int          exp_eop_cyc[$];
    logic [31:0] exp_good = '0, exp_fcs = '0, exp_len = '0;
    logic [31:0] crc_tab[256];
    logic [7:0]  frm[$];
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int k);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < k; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ frm[i]];
        return ~c;
    endfunction

    task automatic build_frame(input int n, input bit flip10);
        logic [31:0] f;
        frm.delete();
        if (n >= 4) begin
            for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom_range(0, 255)));
            f = fcs_of(n - 4);
            frm.push_back(f[7:0]);
            frm.push_back(f[15:8]);
            frm.push_back(f[23:16]);
            frm.push_back(f[31:24]);
        end else begin
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
        end
        if (flip10 && n > 10) frm[10] = frm[10] ^ 8'h04;
    endtask

    // Model the frame in frm, then drive it followed by one idle cycle.
    task automatic drive_frame(input int er_idx);
        int n, beats;
        bit len_bad, fcs_ok, err;
        n = frm.size();
        len_bad = (n < MIN_LEN) || (n > MAX_LEN);
        fcs_ok = (n >= 4) && ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == fcs_of(n - 4));
        err = len_bad || !fcs_ok || (er_idx >= 0 && er_idx < n);
        if (len_bad) exp_len++;
        else if (err) exp_fcs++;
        else exp_good++;
        beats = (n >= HOLD) ? n - HOLD + 1 : 0;
        for (int i = 0; i < beats; i++)
            exp_q.push_back({(i == beats - 1) && err, i == beats - 1, i == 0, frm[i]});
        for (int i = 0; i < n; i++) begin
            @(posedge clk_125m); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
            gmii_rx_er = (i == er_idx);
        end
        @(posedge clk_125m); #1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'($urandom_range(0, 255));
        gmii_rx_er = 1'($urandom_range(0, 1));
        if (beats > 0) begin
            exp_eop_cyc.push_back(cyc + 1);
            exp_cnt_q.push_back({exp_good, exp_fcs, exp_len});
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk_125m); #1;
            gmii_rx_er = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int f0;
        idle(4);
        f0 = n_fail;
        chk({tag, " beats"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s beat%0d", tag, i), obs_q[i], exp_q[i]);
            if (n_fail > f0 + 3) break;
        end
        chk({tag, " eops"}, obs_eop_cyc.size(), exp_eop_cyc.size());
        for (int i = 0; i < obs_eop_cyc.size() && i < exp_eop_cyc.size(); i++) begin
            chk($sformatf("%s eop_cycle%0d", tag, i), obs_eop_cyc[i], exp_eop_cyc[i]);
            chk($sformatf("%s eop_counters%0d", tag, i), obs_cnt_q[i], exp_cnt_q[i]);
        end
        chk({tag, " cnt_good"}, cnt_good, exp_good);
        chk({tag, " cnt_bad_fcs"}, cnt_bad_fcs, exp_fcs);
        chk({tag, " cnt_bad_len"}, cnt_bad_len, exp_len);
        chk({tag, " stray_markers"}, stray, 0);
        obs_q.delete(); exp_q.delete();
        obs_eop_cyc.delete(); exp_eop_cyc.delete();
        obs_cnt_q.delete(); exp_cnt_q.delete();
        stray = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, gap;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        repeat (3) @(posedge clk_125m);
        #1;
        chk("reset pkt_valid", pkt_valid, 1'b0);
        chk("reset pkt_sop", pkt_sop, 1'b0);
        chk("reset pkt_eop", pkt_eop, 1'b0);
        chk("reset pkt_err", pkt_err, 1'b0);
        chk("reset pkt_data", pkt_data, 8'h00);
        chk("reset counters", {cnt_good, cnt_bad_fcs, cnt_bad_len}, 96'd0);
        rst_n = 1'b1;
        idle(2);

        build_frame(64, 1'b0); drive_frame(-1); drain("good64");
        build_frame(64, 1'b1); drive_frame(-1); drain("flip64");
        build_frame(60, 1'b0); drive_frame(-1); drain("short60");
        build_frame(1519, 1'b0); drive_frame(-1); drain("long1519");
        build_frame(1518, 1'b0); drive_frame(-1); drain("max1518");

        build_frame(64, 1'b0); drive_frame(-1);
        build_frame(64, 1'b0); drive_frame(-1);
        drain("back2back");

        build_frame(64, 1'b0); drive_frame(20); drain("rx_er20");

        for (int k = 1; k <= 6; k++) begin
            build_frame(k, 1'b0); drive_frame(-1); idle(1);
        end
        drain("tiny");

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 5))
                0: n = $urandom_range(1, 8);
                1: n = $urandom_range(63, 65);
                2: n = $urandom_range(66, 300);
                3: n = $urandom_range(1517, 1519);
                default: n = $urandom_range(64, 128);
            endcase
            build_frame(n, 1'($urandom_range(0, 3) == 0));
            drive_frame(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1);
            gap = $urandom_range(1, 3);
            idle(gap - 1);
        end
        drain("random");

        // Reset asserted at byte 30, released while the frame is still running.
        build_frame(64, 1'b0);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk_125m); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
            if (i == 30) begin
                rst_n = 1'b0;
                #1;
                chk("midreset pkt_valid", pkt_valid, 1'b0);
                chk("midreset counters", {cnt_good, cnt_bad_fcs, cnt_bad_len}, 96'd0);
                obs_q.delete(); obs_eop_cyc.delete(); obs_cnt_q.delete();
                exp_q.delete(); exp_eop_cyc.delete(); exp_cnt_q.delete();
                exp_good = '0; exp_fcs = '0; exp_len = '0; stray = 0;
            end
            if (i == 33) rst_n = 1'b1;
        end
        @(posedge clk_125m); #1;
        gmii_rx_dv = 1'b0;
        drain("after_reset_tail");
        build_frame(64, 1'b0); drive_frame(-1); drain("after_reset_good");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
